// File: rtl/templatized_alu_sequencer_if.sv
// rtl/templatized_alu_sequencer_if.sv - decode-table config, op-code input and decoded-result handshake bundle
interface templatized_alu_sequencer_if #(
    parameter int OP_W  = 4,
    parameter int SEL_W = 2
);
    logic             cfg_we;
    logic [OP_W-1:0]  cfg_addr;
    logic [SEL_W-1:0] cfg_sel;
    logic             cfg_multi;
    logic             cfg_en;
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op_code;
    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] out_select;
    logic             out_illegal;
    logic [OP_W-1:0]  out_op_code;
    logic             busy;

    modport slave (
        input  cfg_we, cfg_addr, cfg_sel, cfg_multi, cfg_en,
        input  in_valid, in_op_code, out_ready,
        output in_ready, out_valid, out_select, out_illegal, out_op_code, busy
    );

    modport master (
        output cfg_we, cfg_addr, cfg_sel, cfg_multi, cfg_en,
        output in_valid, in_op_code, out_ready,
        input  in_ready, out_valid, out_select, out_illegal, out_op_code, busy
    );
endinterface

// File: rtl/templatized_alu_sequencer.sv
// rtl/templatized_alu_sequencer.sv - programmable op-code to functional-unit decoder with multi-cycle sequencing
module templatized_alu_sequencer #(
    parameter int OP_W        = 4,
    parameter int SEL_W       = 2,
    parameter int NUM_OPS     = 16,
    parameter int MC_LAT      = 3,
    parameter int DEFAULT_SEL = 0
) (
    input logic clk,
    input logic rst_n,
    templatized_alu_sequencer_if.slave bus
);
    localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int TBL_N = 2 ** IDX_W;
    localparam int CNT_W = $clog2(MC_LAT + 1);
    localparam logic [OP_W:0]    NUM_OPS_W = (OP_W + 1)'(NUM_OPS);
    localparam logic [SEL_W-1:0] DEF_SEL   = SEL_W'(DEFAULT_SEL);
    localparam logic [CNT_W-1:0] MC_LOAD   = CNT_W'(MC_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             tbl_en    [TBL_N];
    logic             tbl_multi [TBL_N];
    logic [SEL_W-1:0] tbl_sel   [TBL_N];

    logic             accept;
    logic             dec_legal;
    logic             dec_multi;
    logic [SEL_W-1:0] dec_sel;
    logic [IDX_W-1:0] op_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_ok;

    assign bus.in_ready = (state == IDLE) || (state == HOLD && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign op_idx       = bus.in_op_code[IDX_W-1:0];
    assign wr_idx       = bus.cfg_addr[IDX_W-1:0];
    assign wr_ok        = bus.cfg_we && ({1'b0, bus.cfg_addr} < NUM_OPS_W);

    // Decode reads the table as it stood before this edge, so a colliding write lands one op later.
    always_comb begin
        dec_legal = ({1'b0, bus.in_op_code} < NUM_OPS_W) && tbl_en[op_idx];
        dec_multi = 1'b0;
        dec_sel   = DEF_SEL;
        if (dec_legal) begin
            dec_multi = tbl_multi[op_idx];
            dec_sel   = tbl_sel[op_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_N; i++) begin
                tbl_en[i]    <= 1'b0;
                tbl_multi[i] <= 1'b0;
                tbl_sel[i]   <= DEF_SEL;
            end
            state           <= IDLE;
            cnt             <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_select  <= DEF_SEL;
            bus.out_illegal <= 1'b0;
            bus.out_op_code <= '0;
            bus.busy        <= 1'b0;
        end else begin
            if (wr_ok) begin
                tbl_en[wr_idx]    <= bus.cfg_en;
                tbl_multi[wr_idx] <= bus.cfg_multi;
                tbl_sel[wr_idx]   <= bus.cfg_sel;
            end
            if (accept) begin
                bus.out_select  <= dec_sel;
                bus.out_illegal <= !dec_legal;
                bus.out_op_code <= bus.in_op_code;
                if (dec_multi && MC_LAT > 1) begin
                    state         <= WAIT;
                    cnt           <= MC_LOAD;
                    bus.out_valid <= 1'b0;
                    bus.busy      <= 1'b1;
                end else begin
                    state         <= HOLD;
                    bus.out_valid <= 1'b1;
                end
            end else begin
                case (state)
                    WAIT: begin
                        if (cnt == CNT_W'(1)) begin
                            state         <= HOLD;
                            bus.out_valid <= 1'b1;
                            bus.busy      <= 1'b0;
                        end
                        cnt <= cnt - 1'b1;
                    end
                    HOLD: begin
                        if (bus.out_ready) begin
                            state         <= IDLE;
                            bus.out_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
